midi_apb_master: RTL and testbench

Upstream front end of the synthesizer. Consumes the byte stream from the MIDI UART receiver, parses Note On / Note Off channel messages (with running status), buffers decoded note events in a 4-entry FIFO, and issues them to the synthesizer's APB slave port as fixed-length APB write transfers on PSEL/PENABLE/PWRITE/PWDATA. The synthesizer slave has no PREADY or PSLVERR, so every transfer is exactly two cycles.

---
 rtl/midi_apb_master_if.sv | 26 ++
 rtl/midi_apb_master.sv | 171 +++++++++++++++++
 tb/tb_midi_apb_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_apb_master_if.sv
// midi_apb_master_if
//   Groups the MIDI byte stream from the UART receiver with the APB write
//   port toward the synthesizer.
//   rx_data  [7:0]  received MIDI byte
//   rx_valid        one-cycle strobe qualifying rx_data
//   PSEL, PENABLE, PWRITE, PWDATA[31:0]  APB write transfer (no PREADY/PSLVERR)
//   master modport: the note front end (consumes rx, drives APB)
//   slave modport : the surrounding system (drives rx, observes APB)
interface midi_apb_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;

    modport master (
        input  rx_data, rx_valid,
        output PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output rx_data, rx_valid,
        input  PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/midi_apb_master.sv
// midi_apb_master
//   Parses Note On / Note Off messages (with running status) from the MIDI
//   byte stream, queues decoded note events in a 4-deep FIFO and issues each
//   one as a two-cycle APB write to the synthesizer.
//   Parameters: CHANNEL (accepted channel when OMNI=0), OMNI (accept all).
//   Ports:
//     clk       system clock, rising edge
//     rst       synchronous reset, active-high
//     bus       midi_apb_master_if.master (rx byte stream in, APB write out)
//     overflow  sticky flag: an event was dropped because the FIFO was full
//   Event word: [19:16] channel, [15] gate, [14:8] note, [7] 0, [6:0] velocity,
//   zero-extended to 32 bits on PWDATA.
module midi_apb_master #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    midi_apb_master_if.master  bus,
    output logic               overflow
);

    typedef enum logic [1:0] {P_IDLE, P_D1, P_D2} p_state_t;
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} a_state_t;

    p_state_t    p_state;
    a_state_t    a_state;
    logic [7:0]  run_status;
    logic [6:0]  note;

    logic [7:0]  rx_byte;
    logic [3:0]  rs_type;
    logic        two_data;
    logic        chan_ok;
    logic        evt_valid;
    logic [19:0] evt_word;

    logic [19:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        full;
    logic        pop;
    logic        push;

    assign rx_byte  = bus.rx_data;
    assign rs_type  = run_status[7:4];
    // Program change and channel pressure carry a single data byte.
    assign two_data = (rs_type != 4'hC) && (rs_type != 4'hD);
    assign chan_ok  = OMNI || (run_status[3:0] == CHANNEL);

    // P_D2 is only reachable under a two-data-byte status, so a data byte
    // here always completes a message.
    assign evt_valid = bus.rx_valid && !rx_byte[7] && (p_state == P_D2) &&
                       ((rs_type == 4'h8) || (rs_type == 4'h9)) && chan_ok;
    assign evt_word  = {run_status[3:0],
                        (rs_type == 4'h9) && (rx_byte[6:0] != 7'd0),
                        note, 1'b0, rx_byte[6:0]};

    assign full = (count == 3'd4);
    assign pop  = (a_state == A_IDLE) && (count != 3'd0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push = evt_valid && (!full || pop);

    // Parser: status, running status and data byte tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state    <= P_IDLE;
            run_status <= 8'h00;
        end else if (bus.rx_valid) begin
            if (rx_byte[7]) begin
                // 0xF8-0xFF are realtime bytes and leave the parser untouched.
                if (rx_byte < 8'hF8) begin
                    if (rx_byte >= 8'hF0) begin
                        run_status <= 8'h00;
                        p_state    <= P_IDLE;
                    end else begin
                        run_status <= rx_byte;
                        p_state    <= P_D1;
                    end
                end
            end else begin
                case (p_state)
                    P_IDLE: begin
                        // Running status: a bare data byte starts a new message.
                        if ((run_status != 8'h00) && two_data) begin
                            note    <= rx_byte[6:0];
                            p_state <= P_D2;
                        end
                    end
                    P_D1: begin
                        if (two_data) begin
                            note    <= rx_byte[6:0];
                            p_state <= P_D2;
                        end else begin
                            p_state <= P_IDLE;
                        end
                    end
                    default: p_state <= P_IDLE;
                endcase
            end
        end
    end

    // Event FIFO: storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= evt_word;
        end
    end

    // Event FIFO: pointers, occupancy and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (evt_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // APB write FSM with registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_state     <= A_IDLE;
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.PWRITE  <= 1'b0;
            bus.PWDATA  <= 32'h0;
        end else begin
            case (a_state)
                A_IDLE: begin
                    if (pop) begin
                        bus.PWDATA  <= {12'h000, fifo_mem[rd_ptr]};
                        bus.PSEL    <= 1'b1;
                        bus.PENABLE <= 1'b0;
                        bus.PWRITE  <= 1'b1;
                        a_state     <= A_SETUP;
                    end
                end
                A_SETUP: begin
                    bus.PENABLE <= 1'b1;
                    a_state     <= A_ACCESS;
                end
                default: begin
                    // No PREADY: the access phase always lasts one cycle.
                    bus.PSEL    <= 1'b0;
                    bus.PENABLE <= 1'b0;
                    bus.PWRITE  <= 1'b0;
                    a_state     <= A_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_apb_master.sv
// tb_midi_apb_master
//   Three instances share one MIDI byte stream: channel 0, channel 2 and
//   OMNI. Expected APB words are queued per instance when a message is sent
//   and popped by a monitor when that instance starts a transfer.
module tb_midi_apb_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ovf0, ovf1, ovf2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    midi_apb_master_if if0 ();
    midi_apb_master_if if1 ();
    midi_apb_master_if if2 ();

    assign if0.rx_data = rx_data;  assign if0.rx_valid = rx_valid;
    assign if1.rx_data = rx_data;  assign if1.rx_valid = rx_valid;
    assign if2.rx_data = rx_data;  assign if2.rx_valid = rx_valid;

    midi_apb_master #(.CHANNEL(4'd0), .OMNI(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .overflow(ovf0));
    midi_apb_master #(.CHANNEL(4'd2), .OMNI(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .overflow(ovf1));
    midi_apb_master #(.CHANNEL(4'd0), .OMNI(1'b1)) dut2 (
        .clk(clk), .rst(rst), .bus(if2), .overflow(ovf2));

    logic        psel [3];
    logic        pen  [3];
    logic        pwr  [3];
    logic [31:0] pwd  [3];
    logic        ovf  [3];

    assign psel[0] = if0.PSEL;    assign psel[1] = if1.PSEL;    assign psel[2] = if2.PSEL;
    assign pen[0]  = if0.PENABLE; assign pen[1]  = if1.PENABLE; assign pen[2]  = if2.PENABLE;
    assign pwr[0]  = if0.PWRITE;  assign pwr[1]  = if1.PWRITE;  assign pwr[2]  = if2.PWRITE;
    assign pwd[0]  = if0.PWDATA;  assign pwd[1]  = if1.PWDATA;  assign pwd[2]  = if2.PWDATA;
    assign ovf[0]  = ovf0;        assign ovf[1]  = ovf1;        assign ovf[2]  = ovf2;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];

    function automatic int q_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [31:0] q_pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Queue the word each instance should emit for a completed note message.
    task automatic exp_evt(input logic [3:0] ch, input logic gate,
                           input logic [6:0] nt, input logic [6:0] vel);
        logic [31:0] w;
        w = {12'h000, ch, gate, nt, 1'b0, vel};
        if (ch == 4'd0) q0.push_back(w);
        if (ch == 4'd2) q1.push_back(w);
        q2.push_back(w);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((q0.size() + q1.size() + q2.size()) != 0 ||
                psel[0] || psel[1] || psel[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", {31'd0, n < 200}, 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_psel%0d", tag, i), {31'd0, psel[i]}, 32'd0);
            check($sformatf("%s_pen%0d", tag, i), {31'd0, pen[i]}, 32'd0);
            check($sformatf("%s_pwrite%0d", tag, i), {31'd0, pwr[i]}, 32'd0);
            check($sformatf("%s_pwdata%0d", tag, i), pwd[i], 32'd0);
            check($sformatf("%s_ovf%0d", tag, i), {31'd0, ovf[i]}, 32'd0);
        end
    endtask

    // Bus monitor: every setup phase must match the head of the scoreboard,
    // every access phase must follow a setup with unchanged PWDATA.
    logic        prev_setup [3];
    logic [31:0] prev_wd    [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                prev_setup[i] <= 1'b0;
            end else if (psel[i] && !pen[i]) begin
                check($sformatf("setup_pwrite%0d", i), {31'd0, pwr[i]}, 32'd1);
                if (q_size(i) == 0)
                    check($sformatf("unexpected_xfer%0d", i), {31'd0, psel[i]}, 32'd0);
                else
                    check($sformatf("pwdata%0d", i), pwd[i], q_pop(i));
                prev_setup[i] <= 1'b1;
                prev_wd[i]    <= pwd[i];
            end else if (psel[i] && pen[i]) begin
                check($sformatf("access_after_setup%0d", i), {31'd0, prev_setup[i]}, 32'd1);
                check($sformatf("pwdata_stable%0d", i), pwd[i], prev_wd[i]);
                check($sformatf("access_pwrite%0d", i), {31'd0, pwr[i]}, 32'd1);
                prev_setup[i] <= 1'b0;
            end else begin
                if (pen[i])
                    check($sformatf("penable_alone%0d", i), {31'd0, pen[i]}, 32'd0);
                prev_setup[i] <= 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset with the byte stream active
        @(negedge clk);
        rx_data = 8'h90; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        rx_data = 8'h3C; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("post_reset");

        // Note On on channel 0 with exact transfer timing
        send(8'h90);
        send(8'h3C);
        exp_evt(4'd0, 1'b1, 7'h3C, 7'h64);
        send(8'h64);
        @(negedge clk);
        check("non_t1_psel", {31'd0, if0.PSEL}, 32'd1);
        check("non_t1_pen", {31'd0, if0.PENABLE}, 32'd0);
        @(negedge clk);
        check("non_t2_psel", {31'd0, if0.PSEL}, 32'd1);
        check("non_t2_pen", {31'd0, if0.PENABLE}, 32'd1);
        @(negedge clk);
        check("non_t3_psel", {31'd0, if0.PSEL}, 32'd0);
        check("non_t3_pen", {31'd0, if0.PENABLE}, 32'd0);
        check("non_hold_pwdata", if0.PWDATA, 32'h0000BC64);
        drain();

        // Running status with a velocity-0 Note On on channel 1
        send(8'h91);
        send(8'h40);
        exp_evt(4'd1, 1'b1, 7'h40, 7'h7F);
        send(8'h7F);
        send(8'h40);
        exp_evt(4'd1, 1'b0, 7'h40, 7'h00);
        send(8'h00);
        drain();
        check("running_hold_pwdata", if2.PWDATA, 32'h00014000);

        // Channel filtering, realtime interleave, one-data-byte message
        send(8'h93);
        send(8'h30);
        exp_evt(4'd3, 1'b1, 7'h30, 7'h10);
        send(8'h10);
        send(8'h82);
        send(8'hF8);
        send(8'h30);
        exp_evt(4'd2, 1'b0, 7'h30, 7'h20);
        send(8'h20);
        send(8'hC2);
        send(8'h05);
        drain();
        check("filter_hold_pwdata1", if1.PWDATA, 32'h00023020);

        // System byte abandons a partial message and clears running status
        send(8'h90);
        send(8'h3C);
        send(8'hF0);
        send(8'h45);
        send(8'h45);
        drain();
        send(8'h90);
        send(8'h45);
        exp_evt(4'd0, 1'b1, 7'h45, 7'h01);
        send(8'h01);
        drain();
        check("abort_hold_pwdata0", if0.PWDATA, 32'h0000C501);

        // Overflow: a message every two cycles outruns one transfer per three.
        // The 12th completes on a full FIFO while the head pops (kept);
        // the 13th arrives full with no pop (dropped).
        check("ovf_before0", {31'd0, ovf0}, 32'd0);
        send(8'h90);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) send(8'h10 + 8'(i));
            else       send(8'h10);
            if (i < 12) exp_evt(4'd0, 1'b1, 7'h10 + 7'(i), 7'h40);
            send(8'h40);
            if (i == 11) begin
                check("ovf_full_pop0", {31'd0, ovf0}, 32'd0);
                check("ovf_full_pop2", {31'd0, ovf2}, 32'd0);
            end
        end
        check("ovf_set0", {31'd0, ovf0}, 32'd1);
        check("ovf_set2", {31'd0, ovf2}, 32'd1);
        check("ovf_clear1", {31'd0, ovf1}, 32'd0);
        drain();
        repeat (10) @(negedge clk);
        check("ovf_sticky0", {31'd0, ovf0}, 32'd1);
        check("ovf_sticky2", {31'd0, ovf2}, 32'd1);

        // Reset in the setup phase of the second transfer with a third queued
        send(8'h90);
        send(8'h50);
        exp_evt(4'd0, 1'b1, 7'h50, 7'h10);
        send(8'h10);
        send(8'h51);
        exp_evt(4'd0, 1'b1, 7'h51, 7'h10);
        send(8'h10);
        send(8'h52);
        send(8'h10);
        check("mid_setup_psel0", {31'd0, if0.PSEL}, 32'd1);
        check("mid_setup_pen0", {31'd0, if0.PENABLE}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (15) @(negedge clk);
        check_all_zero("after_mid_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
